// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between pipeline writeback (A) and the multi-cycle unit (B).
// Latency: accept at edge N drives we3/wa3/wd3 for all of cycle N+1; one write per cycle, no bubbles.
// Backpressure: A wins by default; B is forced through after STARVE_LIMIT consecutive denied cycles.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 3   // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              b_starved
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } state_t;

  // Count value that, once incremented, reaches the starvation limit.
  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       a_acc;
  logic       b_acc;

  // Each ready depends only on state and the other side's valid, so a
  // requester can never see its own valid loop back into its ready.
  assign a_ready = (state == PRIO_A) ? 1'b1 : !b_valid;
  assign b_ready = (state == PRIO_B) ? 1'b1 : !a_valid;

  // The ready rules make these mutually exclusive.
  assign a_acc = a_valid & a_ready;
  assign b_acc = b_valid & b_ready;

  // Priority FSM with starvation counter and the one-cycle starved pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PRIO_A;
      starve_cnt <= 4'd0;
      b_starved  <= 1'b0;
    end else begin
      b_starved <= 1'b0;
      if (state == PRIO_A) begin
        if (!b_valid || b_acc) begin
          starve_cnt <= 4'd0;
        end else begin
          starve_cnt <= starve_cnt + 4'd1;
          if (starve_cnt == LIMIT_M1) begin
            state     <= PRIO_B;
            b_starved <= 1'b1;
          end
        end
      end else begin
        // In PRIO_B, B is always ready: either it is accepted now or it has
        // dropped valid. Both cases return to PRIO_A after one cycle.
        state      <= PRIO_A;
        starve_cnt <= 4'd0;
      end
    end
  end

  // Register the winning write; writes to $zero complete but do not enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else if (a_acc) begin
      we3 <= (a_addr != '0);
      wa3 <= a_addr;
      wd3 <= a_data;
    end else if (b_acc) begin
      we3 <= (b_addr != '0);
      wa3 <= b_addr;
      wd3 <= b_data;
    end else begin
      we3 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized requesters.
// A reference model of the arbitration rules is checked every negative edge.
// A small register file in the bench absorbs the DUT's writes for read-back.
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic [4:0]  a_addr = '0;
  logic [31:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_addr = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        b_starved;

  int n_total = 0;
  int n_bad   = 0;

  regfile_wb_arbiter #(
    .DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3), .b_starved(b_starved)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT's write port; reg 0 always reads zero.
  logic [31:0] rf [32];
  always @(posedge clk) if (we3) rf[wa3] <= wd3;

  function automatic logic [31:0] rf_rd(input logic [4:0] addr);
    return (addr == 5'd0) ? 32'd0 : rf[addr];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: B is forced through once it has been refused LIMIT
  // cycles in a row; otherwise A has priority. Writes appear one cycle
  // after acceptance, in acceptance order.
  int          m_denied = 0;
  logic        m_we = 1'b0, l_we = 1'b0;
  logic [4:0]  m_wa = '0,   l_wa = '0;
  logic [31:0] m_wd = '0,   l_wd = '0;
  logic        m_starved = 1'b0;
  logic [31:0] exp_rf [32];

  always @(negedge clk) begin
    logic forced, exp_ar, exp_br, acc_a, acc_b;
    int k;
    // the write shown during the previous cycle has landed in rf
    if (l_we) exp_rf[l_wa] = l_wd;
    if (reset) begin
      m_denied = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_starved = 1'b0;
    end
    forced = (m_denied >= LIMIT);
    exp_ar = forced ? !b_valid : 1'b1;
    exp_br = forced ? 1'b1 : !a_valid;
    check("a_ready", 32'(a_ready), 32'(exp_ar));
    check("b_ready", 32'(b_ready), 32'(exp_br));
    check("we3", 32'(we3), 32'(m_we));
    check("wa3", 32'(wa3), 32'(m_wa));
    check("wd3", 32'(wd3), m_wd);
    check("b_starved", 32'(b_starved), 32'(m_starved));
    k = $urandom_range(1, 31);
    check("rf_contents", rf[k], exp_rf[k]);
    l_we = m_we; l_wa = m_wa; l_wd = m_wd;
    if (!reset) begin
      acc_a = a_valid && exp_ar;
      acc_b = b_valid && exp_br;
      if (acc_a) begin
        m_we = (a_addr != 5'd0); m_wa = a_addr; m_wd = a_data;
      end else if (acc_b) begin
        m_we = (b_addr != 5'd0); m_wa = b_addr; m_wd = b_data;
      end else begin
        m_we = 1'b0;
      end
      if (b_valid && !acc_b) m_denied++;
      else m_denied = 0;
      m_starved = (m_denied >= LIMIT);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic took_a, took_b;
    int   a_pct, b_pct;
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'd0;
      exp_rf[i] = 32'd0;
    end

    // Power-on reset
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    check("por_we3", 32'(we3), 32'd0);
    check("por_wa3", 32'(wa3), 32'd0);
    check("por_wd3", wd3, 32'd0);
    check("por_a_ready", 32'(a_ready), 32'd1);

    // Asynchronous reset mid-cycle while A is valid
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'hDEADBEEF;
    step();
    check("pre_rst_we3", 32'(we3), 32'd1);
    check("pre_rst_wa3", 32'(wa3), 32'd9);
    #1 reset = 1'b1;
    #1;
    check("rst_we3", 32'(we3), 32'd0);
    check("rst_wa3", 32'(wa3), 32'd0);
    check("rst_wd3", wd3, 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    step();
    reset = 1'b0; a_valid = 1'b0;
    step();

    // Single A write and register-file read-back
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA5A5A5A5;
    #1 check("a1_ready", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    check("a1_we3", 32'(we3), 32'd1);
    check("a1_wa3", 32'(wa3), 32'd1);
    check("a1_wd3", wd3, 32'hA5A5A5A5);
    step();
    check("a1_rd", rf_rd(5'd1), 32'hA5A5A5A5);

    // B write with A idle
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h5A5A5A5A;
    #1 check("b2_ready", 32'(b_ready), 32'd1);
    step();
    b_valid = 1'b0;
    check("b2_we3", 32'(we3), 32'd1);
    check("b2_wa3", 32'(wa3), 32'd2);
    check("b2_starved", 32'(b_starved), 32'd0);
    step();

    // Starvation: A streams regs 3..6, B holds reg 7
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h12345678;
    #1 check("st_b_denied", 32'(b_ready), 32'd0);
    step();
    check("st_wa3_0", 32'(wa3), 32'd3);
    check("st_starved_0", 32'(b_starved), 32'd0);
    a_addr = 5'd4; a_data = 32'h44;
    step();
    check("st_wa3_1", 32'(wa3), 32'd4);
    a_addr = 5'd5; a_data = 32'h55;
    step();
    check("st_wa3_2", 32'(wa3), 32'd5);
    a_addr = 5'd6; a_data = 32'h66;
    #1;
    check("st_starved_pulse", 32'(b_starved), 32'd1);
    check("st_a_blocked", 32'(a_ready), 32'd0);
    check("st_b_forced", 32'(b_ready), 32'd1);
    step();
    b_valid = 1'b0;
    check("st_wa3_3", 32'(wa3), 32'd7);
    check("st_wd3_3", wd3, 32'h12345678);
    check("st_starved_end", 32'(b_starved), 32'd0);
    check("st_a_back", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    check("st_wa3_4", 32'(wa3), 32'd6);
    check("st_wd3_4", wd3, 32'h66);
    step();

    // Write to $zero is acknowledged but dropped
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFFFFFF;
    #1 check("z_ready", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    check("z_we3", 32'(we3), 32'd0);
    check("z_wd3", wd3, 32'hFFFFFFFF);
    step();
    check("z_rd", rf_rd(5'd0), 32'd0);

    // Back-to-back alternating A/B, distinct registers
    for (int k = 0; k < 8; k++) begin
      a_valid = (k % 2 == 0); b_valid = (k % 2 == 1);
      a_addr = 5'(10 + k); b_addr = 5'(10 + k);
      a_data = 32'(32'h100 + k); b_data = 32'(32'h200 + k);
      step();
      check("b2b_we3", 32'(we3), 32'd1);
      check("b2b_wa3", 32'(wa3), 32'(10 + k));
      check("b2b_starved", 32'(b_starved), 32'd0);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    check("b2b_rd_a", rf_rd(5'd14), 32'h104);
    check("b2b_rd_b", rf_rd(5'd17), 32'h207);

    // Randomized requesters obeying the hold-until-accepted rule
    for (int cyc = 0; cyc < 3000; cyc++) begin
      a_pct = (cyc < 1000) ? 95 : ((cyc < 2000) ? 50 : 20);
      b_pct = 70;
      @(negedge clk);
      #1;
      took_a = a_valid && a_ready;
      took_b = b_valid && b_ready;
      step();
      if (reset) reset = 1'b0;
      if (!a_valid || took_a) begin
        a_valid = ($urandom_range(0, 99) < a_pct);
        a_addr  = 5'($urandom_range(0, 31));
        a_data  = $urandom;
      end
      if (!b_valid || took_b) begin
        b_valid = ($urandom_range(0, 99) < b_pct);
        b_addr  = 5'($urandom_range(0, 31));
        b_data  = $urandom;
      end
      if (cyc % 500 == 250) begin
        #1 reset = 1'b1;
      end
    end

    a_valid = 1'b0; b_valid = 1'b0;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the 32x32 MIPS register file (`regfile`, single write port `we3`/`wa3`/`wd3`). It shares that one port between two writeback requesters:

- **A:** the main pipeline writeback, high priority.
- **B:** the multi-cycle unit (mult/div, load return), low priority with starvation protection.

Each requester uses a valid/ready handshake. Each accepted write is presented to the register file as a registered single-cycle pulse.

## Interface
Parameters:
- `DATA_W`, 32, write-data width
- `ADDR_W`, 5, register-address width
- `STARVE_LIMIT`, 3, consecutive denied B cycles before B is forced to win (legal range 1..15)

Ports:
- `clk`  input  1  clock; all state updates on posedge
- `reset`  input  1  asynchronous, active-high reset
- `a_valid`  input  1  requester A holds a write
- `a_addr`  input  ADDR_W  A destination register
- `a_data`  input  DATA_W  A write data
- `a_ready`  output  1  A accepted this cycle when `a_valid & a_ready`
- `b_valid`  input  1  requester B holds a write
- `b_addr`  input  ADDR_W  B destination register
- `b_data`  input  DATA_W  B write data
- `b_ready`  output  1  B accepted this cycle when `b_valid & b_ready`
- `we3`  output  1  register-file write enable (registered)
- `wa3`  output  ADDR_W  register-file write address (registered)
- `wd3`  output  DATA_W  register-file write data (registered)
- `b_starved`  output  1  one-cycle pulse, registered: forced-B state entered

## Operation
- **Handshake rules (requester obligations):**
  - Requesters hold valid, addr and data stable until accepted.
  - At most one requester is accepted per cycle.
- **FSM, two states:**
  - **PRIO_A (reset state):**
    - `a_ready`=1.
    - `b_ready`=!`a_valid`.
  - **PRIO_B:**
    - `b_ready`=1.
    - `a_ready`=!`b_valid`.
- **Starvation counter (`starve_cnt`, 4 bits):**
  - In PRIO_A, increments on every edge where `b_valid & !b_ready`.
  - Cleared on any edge where `b_valid`=0, or where B is accepted.
- **Transitions:**
  - PRIO_A -> PRIO_B at the edge where the increment brings `starve_cnt` to `STARVE_LIMIT`. `b_starved`=1 in the following cycle only.
  - PRIO_B -> PRIO_A at the edge where B is accepted or `b_valid`=0; `starve_cnt` is cleared.
  - PRIO_B never persists more than one accept.
- **Write register:**
  - On the accept edge, `wa3`/`wd3` load the winner's addr/data.
  - `we3` loads 1 unless addr==0.
  - Writes to $zero complete the handshake but are dropped: `we3`=0, while `wa3`/`wd3` still update.
  - No accept on an edge -> `we3` loads 0; `wa3`/`wd3` hold.
- **Ordering:** writes reach the register file in acceptance order. Same-address writes from A and B are not merged; the later accept wins.
- **Reset (asynchronous, any time, including mid-handshake):**
  - State=PRIO_A, `starve_cnt`=0, `we3`=0, `wa3`=0, `wd3`=0, `b_starved`=0.
  - A write accepted at the edge coinciding with reset assertion is discarded.
  - Outputs while reset is asserted: `a_ready`=1; `b_ready`=!`a_valid`.

## Timing
- `a_ready`/`b_ready` are combinational from FSM state and the opposite requester's valid only. There is no path from own valid to own ready.
- **Latency:** accept at edge N -> `we3`/`wa3`/`wd3` valid throughout cycle N+1 -> register file writes at edge N+1. A read issued in cycle N+2 returns the new value.
- **Throughput:** one write per cycle, back-to-back, no bubbles.
- **Worst-case B wait:** `STARVE_LIMIT`+1 cycles from `b_valid` rising.
- **Worst-case A wait:** 1 cycle.

## Test plan
- **Reset values:** assert `reset` asynchronously mid-cycle with `a_valid`=1 -> `we3`=0, `wa3`=0, `wd3`=0 immediately; `a_ready`=1, `b_ready`=0.
- **Single A write:** `a_valid`=1, `a_addr`=1, `a_data`=0xA5A5A5A5 for one cycle -> next cycle `we3`=1, `wa3`=1, `wd3`=0xA5A5A5A5; `regfile` reads rd1=0xA5A5A5A5 from cycle N+2.
- **Idle A, B write:** `a_valid`=0, `b_valid`=1, `b_addr`=2, `b_data`=0x5A5A5A5A -> `b_ready`=1 same cycle; `we3`=1, `wa3`=2 next cycle; `b_starved` stays 0.
- **Starvation, `STARVE_LIMIT`=3:** A streams to regs 3,4,5,6 and B holds reg 7 = 0x12345678 from edge 0.
  - B denied at edges 1-3; B accepted at edge 4.
  - `b_starved`=1 in cycle 4 only; `a_ready`=0 in cycle 4.
  - A's reg-6 write is accepted at edge 5.
  - `wa3` sequence: 3,4,5,7,6.
- **$zero write:** A writes addr 0, data 0xFFFFFFFF -> `a_ready`=1, next cycle `we3`=0; rd of reg 0 returns 0.
- **Back-to-back mixed:** A and B alternate `valid` every cycle with distinct regs for 8 cycles -> `we3`=1 on every cycle after the first accept; no lost or duplicated address; `starve_cnt` never reaches 3.
